// File: rtl/argmax_pkg.sv
// Shared types and sizes for the argmax classification head.
// M elements per vector, T-bit signed elements, IW-bit element index.
package argmax_pkg;

  localparam int unsigned M  = 8;
  localparam int unsigned T  = 16;
  localparam int unsigned IW = $clog2(M);

  typedef logic signed [T-1:0] elem_t;
  typedef logic [IW-1:0]       idx_t;

  typedef struct packed {
    idx_t  idx;
    elem_t val;
  } result_t;

  // Index of the final element of a vector; its transfer completes the result.
  localparam idx_t LastIdx = idx_t'(M - 1);

endpackage

// File: rtl/argmax_8_16_if.sv
// Streaming interface of argmax_8_16.
//   input_valid/input_ready/input_data      : element stream from the fc layer
//   output_valid/output_ready/output_index,
//   output_data                             : per-vector {index, maximum} result
// slave  : the argmax block's view
// master : the environment's view (drives elements, consumes results)
interface argmax_8_16_if;
  import argmax_pkg::*;

  logic  input_valid;
  logic  input_ready;
  elem_t input_data;
  logic  output_valid;
  logic  output_ready;
  idx_t  output_index;
  elem_t output_data;

  modport slave (
    input  input_valid,
    output input_ready,
    input  input_data,
    output output_valid,
    input  output_ready,
    output output_index,
    output output_data
  );

  modport master (
    output input_valid,
    input  input_ready,
    output input_data,
    input  output_valid,
    output output_ready,
    input  output_index,
    input  output_data
  );

endinterface

// File: rtl/argmax_outbuf.sv
// One-entry valid/ready output register for a completed argmax result.
//   clk, reset        : clock, asynchronous active-low reset
//   load, load_data   : write a freshly completed result
//   out_ready         : downstream accepts the held result
//   out_valid         : a result is held
//   out_data          : held {idx, val}
//   full_and_stalled  : holding a result that is not being taken this cycle
// A load and a drain on the same edge replace the entry and keep out_valid high.
module argmax_outbuf
  import argmax_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    load,
  input  result_t load_data,
  input  logic    out_ready,
  output logic    out_valid,
  output result_t out_data,
  output logic    full_and_stalled
);

  logic    valid_q, valid_d;
  result_t data_q;

  always_comb begin
    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load) begin
        data_q <= load_data;
      end
    end
  end

  assign out_valid        = valid_q;
  assign out_data         = data_q;
  assign full_and_stalled = valid_q && !out_ready;

  // The producer must never overwrite a result that is still waiting.
  no_overwrite_a: assert property (@(posedge clk) disable iff (!reset)
    load |-> !full_and_stalled);

endmodule

// File: rtl/argmax_8_16.sv
// Argmax head: for each vector of M signed elements, reports the index of the
// largest element (lowest index on ties) and its value.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : element input stream and result output stream (argmax_8_16_if.slave)
// The running max accumulates the next vector while a finished result waits in
// the output register; input stalls only when the last element of a vector
// would overwrite a result that has not been taken.
module argmax_8_16
  import argmax_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  argmax_8_16_if.slave  bus
);

  idx_t    cnt_q, cnt_d;
  idx_t    idx_q, idx_d;
  elem_t   max_q, max_d;

  logic    is_last;
  logic    in_fire;
  logic    take;
  logic    complete;
  logic    stalled;
  idx_t    cand_idx;
  elem_t   cand_max;
  result_t res_out;

  assign is_last         = (cnt_q == LastIdx);
  assign bus.input_ready = reset && !(is_last && stalled);
  assign in_fire         = bus.input_valid && bus.input_ready;

  // First element always loads; later ones only on a strictly larger value.
  assign take     = (cnt_q == '0) || (bus.input_data > max_q);
  assign cand_idx = take ? cnt_q : idx_q;
  assign cand_max = take ? bus.input_data : max_q;
  assign complete = in_fire && is_last;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    max_d = max_q;
    if (in_fire) begin
      idx_d = cand_idx;
      max_d = cand_max;
      cnt_d = is_last ? '0 : cnt_q + idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      max_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      max_q <= max_d;
    end
  end

  argmax_outbuf u_outbuf (
    .clk              (clk),
    .reset            (reset),
    .load             (complete),
    .load_data        ('{idx: cand_idx, val: cand_max}),
    .out_ready        (bus.output_ready),
    .out_valid        (bus.output_valid),
    .out_data         (res_out),
    .full_and_stalled (stalled)
  );

  assign bus.output_index = res_out.idx;
  assign bus.output_data  = res_out.val;

endmodule

// File: tb/tb_argmax_8_16.sv
module tb_argmax_8_16;

  logic clk;
  logic reset;

  argmax_8_16_if bus ();

  argmax_8_16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0][15:0] e;
    logic [2:0]       ix;
    logic [15:0]      v;
  } vec_t;

  localparam int NV = 7;
  localparam int NR = 40;

  vec_t vecs [NV];
  int   rv   [NR][8];
  int   rix  [NR];
  int   rmx  [NR];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int a4, input int a5, input int a6, input int a7,
                              input int ix, input int v);
    vec_t r;
    r.e[0] = 16'(a0); r.e[1] = 16'(a1); r.e[2] = 16'(a2); r.e[3] = 16'(a3);
    r.e[4] = 16'(a4); r.e[5] = 16'(a5); r.e[6] = 16'(a6); r.e[7] = 16'(a7);
    r.ix = 3'(ix);
    r.v  = 16'(v);
    return r;
  endfunction

  // Drive one element and hold it until the DUT accepts it; returns just after
  // the accepting edge.
  task automatic send(input int v);
    int n;
    n = 0;
    bus.input_valid = 1'b1;
    bus.input_data  = 16'(v);
    #1;
    while (!bus.input_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input int ix, input int v);
    chk({name, "_valid"}, int'(bus.output_valid), 1);
    chk({name, "_index"}, int'(bus.output_index), ix);
    chk({name, "_data"}, int'(bus.output_data), v);
  endtask

  initial begin
    vec_t            vc;
    logic signed [15:0] r16;
    int              got;
    int              sent;
    int              cyc;
    bit              acc;
    bit              cons;

    vecs[0] = mk(3, -5, 7, 7, 2, 0, -1, 6, 2, 7);
    vecs[1] = mk(-8, -3, -32768, -3, -9, -100, -4, -5, 1, -3);
    vecs[2] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767, 7, 32767);
    vecs[3] = mk(5, 5, 5, 5, 5, 5, 5, 5, 0, 5);
    vecs[4] = mk(-1, -2, -3, -4, -5, -6, -7, -8, 0, -1);
    vecs[5] = mk(1, 2, 3, 4, 5, 6, 7, 8, 7, 8);
    vecs[6] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 1);

    // Random vectors and their expected argmax from a reference loop.
    for (int k = 0; k < NR; k++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          rv[k][i] = int'($urandom_range(0, 6)) - 3;
        end else begin
          r16 = 16'($urandom);
          rv[k][i] = int'(r16);
        end
      end
      rix[k] = 0;
      rmx[k] = rv[k][0];
      for (int i = 1; i < 8; i++) begin
        if (rv[k][i] > rmx[k]) begin
          rmx[k] = rv[k][i];
          rix[k] = i;
        end
      end
    end

    reset            = 1'b0;
    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    bus.output_ready = 1'b0;

    // Reset state.
    @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.output_valid), 0);
    chk("rst_index", int'(bus.output_index), 0);
    chk("rst_data", int'(bus.output_data), 0);
    chk("rst_ready", int'(bus.input_ready), 0);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Table vectors, downstream always ready.
    bus.output_ready = 1'b1;
    for (int k = 0; k < NV; k++) begin
      vc = vecs[k];
      for (int i = 0; i < 7; i++) send(int'($signed(vc.e[i])));
      bus.input_valid = 1'b1;
      bus.input_data  = vc.e[7];
      #1;
      chk("pre_last_valid", int'(bus.output_valid), 0);
      chk("pre_last_ready", int'(bus.input_ready), 1);
      @(posedge clk);
      #1;
      bus.input_valid = 1'b0;
      chk_out("vec", int'(vc.ix), int'($signed(vc.v)));
      @(posedge clk);
      #1;
      chk("drained", int'(bus.output_valid), 0);
    end

    // Backpressure: two vectors back to back, downstream stalled.
    bus.output_ready = 1'b0;
    vc = vecs[0];
    for (int i = 0; i < 8; i++) send(int'($signed(vc.e[i])));
    chk_out("bp_first", 2, 7);
    send(-1); send(10); send(-20); send(10); send(0); send(0); send(0);
    chk_out("bp_held", 2, 7);
    bus.input_valid = 1'b1;
    bus.input_data  = 16'(4);
    #1;
    for (int n = 0; n < 3; n++) begin
      chk("bp_stall_ready", int'(bus.input_ready), 0);
      chk_out("bp_stall", 2, 7);
      @(posedge clk);
      #1;
    end
    bus.output_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(bus.input_ready), 1);
    @(posedge clk);
    #1;
    bus.output_ready = 1'b0;
    bus.input_valid  = 1'b0;
    chk_out("bp_second", 1, 10);
    @(posedge clk);
    #1;
    chk_out("bp_second_held", 1, 10);
    bus.output_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drained", int'(bus.output_valid), 0);

    // Reset mid-vector with a result pending.
    bus.output_ready = 1'b0;
    vc = vecs[5];
    for (int i = 0; i < 8; i++) send(int'($signed(vc.e[i])));
    chk_out("mid_pending", 7, 8);
    send(9); send(1); send(1); send(1);
    bus.input_valid = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.output_valid), 0);
    chk("mid_rst_data", int'(bus.output_data), 0);
    chk("mid_rst_ready", int'(bus.input_ready), 0);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_after_valid", int'(bus.output_valid), 0);
    bus.output_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(i);
    chk("mid_no_early", int'(bus.output_valid), 0);
    send(-1);
    bus.input_valid = 1'b0;
    chk_out("mid_result", 6, 6);
    @(posedge clk);
    #1;

    // Randomised handshake on both sides against the precomputed results.
    got  = 0;
    sent = 0;
    cyc  = 0;
    while (got < NR && cyc < 20000) begin
      bus.output_ready = 1'($urandom_range(0, 1));
      if (sent < NR * 8 && $urandom_range(0, 1) == 1) begin
        bus.input_valid = 1'b1;
        bus.input_data  = 16'(rv[sent / 8][sent % 8]);
      end else begin
        bus.input_valid = 1'b0;
        bus.input_data  = 'x;
      end
      #1;
      acc  = bus.input_valid && bus.input_ready;
      cons = bus.output_valid && bus.output_ready;
      if (cons) begin
        chk("rnd_index", int'(bus.output_index), rix[got]);
        chk("rnd_data", int'(bus.output_data), rmx[got]);
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
      cyc++;
    end
    chk("rnd_count", got, NR);
    chk("rnd_sent", sent, NR * 8);
    bus.input_valid  = 1'b0;
    bus.output_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rnd_no_extra", int'(bus.output_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
